// File: rtl/lsu_axil_pkg.sv
// Shared types and constants for the LSU to AXI4-Lite bridge.
// Optional watchdog is enabled with LSU_AXIL_MASTER_TIMEOUT_EN.
package lsu_axil_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4,
      DONE  = 3'd5
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // Latched LSU request
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wmask;
      logic              wen;
   } req_t;

   // SLVERR and DECERR are errors; OKAY and EXOKAY are not
   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      err = 1'b0;
      case (resp)
         OKAY, EXOKAY:   err = 1'b0;
         SLVERR, DECERR: err = 1'b1;
         default:        err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_axil_master_if.sv
// AXI4-Lite channel bundle between the bridge (master) and interconnect (slave).
interface lsu_axil_master_if;
   import lsu_axil_pkg::*;

   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata_o;
   logic [STRB_W-1:0] wstrb;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata_i;
   logic [1:0]        rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata_o, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata_i, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata_o, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata_i, rresp
   );

endinterface

// File: rtl/lsu_axil_watchdog.sv
// Busy-cycle watchdog; expired is high in the TIMEOUT_CYCLES-th busy cycle.
// Used by lsu_axil_master only when LSU_AXIL_MASTER_TIMEOUT_EN is defined.
module lsu_axil_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic busy,
   input  logic clear,
   output logic expired
);

   localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q;

   // Count busy cycles, saturating at the limit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (busy && (count_q != LIMIT)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   // count_q holds completed busy cycles, so the current cycle is count_q+1
   assign expired = busy && (count_q >= (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/lsu_axil_master.sv
// Bridges the LSU single-outstanding memory port onto AXI4-Lite.
// Define LSU_AXIL_MASTER_TIMEOUT_EN to enable the slave-hang watchdog.
module lsu_axil_master
   import lsu_axil_pkg::*;
`ifdef LSU_AXIL_MASTER_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   input  logic               wen,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [STRB_W-1:0]  wmask,
   output logic               resp_valid,
   output logic [DATA_W-1:0]  rdata,
   output logic               resp_err,
   lsu_axil_master_if.master  axi
);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              complete_c;
   logic              timeout_c;

   // Byte-offset bits never reach the bus
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr[1:0];

`ifdef LSU_AXIL_MASTER_TIMEOUT_EN
   lsu_axil_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .busy    (state_q != IDLE),
      .clear   (state_q == IDLE),
      .expired (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Next-state and completion capture
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      complete_c = 1'b0;

      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (req_valid) begin
               req_d.addr  = {addr[ADDR_W-1:2], 2'b00};
               req_d.wdata = wdata;
               req_d.wmask = wmask;
               req_d.wen   = wen;
               state_d     = wen ? WRITE : RADDR;
            end
         end
         WRITE: begin
            // Each valid is up only while its done flag is clear
            aw_done_d = aw_done_q | axi.awready;
            w_done_d  = w_done_q | axi.wready;
            if (aw_done_d && w_done_d) begin
               state_d = WRESP;
            end
         end
         WRESP: begin
            if (axi.bvalid) begin
               complete_c = 1'b1;
               state_d    = DONE;
            end
         end
         RADDR: begin
            if (axi.arready) begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            if (axi.rvalid) begin
               complete_c = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (complete_c) begin
         rdata_d = req_q.wen ? '0 : axi.rdata_i;
         err_d   = resp_is_err(req_q.wen ? axi.bresp : axi.rresp);
      end

      // Slave hang: abandon the transaction and report an error
      if (timeout_c && (state_q != IDLE) && (state_q != DONE)) begin
         state_d = DONE;
         rdata_d = '0;
         err_d   = 1'b1;
      end
   end

   assign axi.awvalid = (state_q == WRITE) && !aw_done_q;
   assign axi.wvalid  = (state_q == WRITE) && !w_done_q;
   assign axi.bready  = (state_q == WRESP);
   assign axi.arvalid = (state_q == RADDR);
   assign axi.rready  = (state_q == RDATA);
   assign axi.awaddr  = req_q.addr;
   assign axi.araddr  = req_q.addr;
   assign axi.wdata_o = req_q.wdata;
   assign axi.wstrb   = req_q.wmask;
   assign axi.awprot  = PROT_DEFAULT;
   assign axi.arprot  = PROT_DEFAULT;

   assign resp_valid = (state_q == DONE);
   assign rdata      = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Scoreboard bench for lsu_axil_master with a scripted AXI4-Lite slave.
// Timeout scenario runs only when LSU_AXIL_MASTER_TIMEOUT_EN is defined.
module tb_lsu_axil_master;
   import lsu_axil_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        resp_err;

   int   n_checks   = 0;
   int   n_fail     = 0;
   int   resp_count = 0;
   int   exp_resps  = 0;
   exp_t sb[$];

   lsu_axil_master_if axi ();

`ifdef LSU_AXIL_MASTER_TIMEOUT_EN
   lsu_axil_master #(.TIMEOUT_CYCLES(8)) dut (
`else
   lsu_axil_master dut (
`endif
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .wen        (wen),
      .addr       (addr),
      .wdata      (wdata),
      .wmask      (wmask),
      .resp_valid (resp_valid),
      .rdata      (rdata),
      .resp_err   (resp_err),
      .axi        (axi)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Requests must only arrive while the bridge is idle
   always @(posedge clock) begin
      if (!reset && req_valid)
         check("req_only_in_idle", 32'(dut.state_q == IDLE), 32'd1);
   end

   // Scoreboard: every completion pulse consumes one expectation
   always @(negedge clock) begin
      if (resp_valid) begin
         resp_count++;
         if (sb.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_rdata", rdata, e.rdata);
            check("resp_err", 32'(resp_err), 32'(e.err));
         end
      end
   end

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] er, input logic ee);
      exp_t e;
      req_valid = 1'b1;
      wen       = w;
      addr      = a;
      wdata     = d;
      wmask     = m;
      e.rdata   = er;
      e.err     = ee;
      sb.push_back(e);
      exp_resps++;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr,
                          input int ar_stall, input int r_stall);
      logic [31:0] word_addr;
      word_addr = a & 32'hFFFF_FFFC;
      issue(1'b0, a, 32'h0, 4'h0, d, rr[1]);
      for (int s = 0; s <= ar_stall; s++) begin
         axi.arready = (s == ar_stall);
         check("rd_arvalid", 32'(axi.arvalid), 32'd1);
         check("rd_araddr", axi.araddr, word_addr);
         check("rd_rready_early", 32'(axi.rready), 32'd0);
         tick();
      end
      axi.arready = 1'b0;
      for (int s = 0; s <= r_stall; s++) begin
         axi.rvalid  = (s == r_stall);
         axi.rdata_i = (s == r_stall) ? d : 32'hDEAD_BEEF;
         axi.rresp   = rr;
         check("rd_arvalid_drop", 32'(axi.arvalid), 32'd0);
         check("rd_rready", 32'(axi.rready), 32'd1);
         check("rd_resp_early", 32'(resp_valid), 32'd0);
         tick();
      end
      axi.rvalid = 1'b0;
      check("rd_resp_pulse", 32'(resp_valid), 32'd1);
      tick();
      check("rd_resp_single", 32'(resp_valid), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input int aw_lat, input int w_lat, input int b_stall,
                           input logic [1:0] br);
      int last;
      last = (aw_lat > w_lat) ? aw_lat : w_lat;
      issue(1'b1, a, d, m, 32'h0, br[1]);
      for (int c = 0; c <= last; c++) begin
         axi.awready = (c == aw_lat);
         axi.wready  = (c == w_lat);
         check("wr_awvalid", 32'(axi.awvalid), 32'(c <= aw_lat));
         check("wr_wvalid", 32'(axi.wvalid), 32'(c <= w_lat));
         check("wr_bready_early", 32'(axi.bready), 32'd0);
         check("wr_awaddr", axi.awaddr, a & 32'hFFFF_FFFC);
         check("wr_wdata", axi.wdata_o, d);
         check("wr_wstrb", 32'(axi.wstrb), 32'(m));
         tick();
      end
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      for (int s = 0; s <= b_stall; s++) begin
         axi.bvalid = (s == b_stall);
         axi.bresp  = br;
         check("wr_bready", 32'(axi.bready), 32'd1);
         check("wr_valids_drop", 32'({axi.awvalid, axi.wvalid}), 32'd0);
         check("wr_resp_early", 32'(resp_valid), 32'd0);
         tick();
      end
      axi.bvalid = 1'b0;
      check("wr_resp_pulse", 32'(resp_valid), 32'd1);
      tick();
      check("wr_resp_single", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit expired");
   end

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      wen         = 1'b0;
      addr        = '0;
      wdata       = '0;
      wmask       = '0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bresp   = OKAY;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata_i = '0;
      axi.rresp   = OKAY;
      repeat (2) @(posedge clock);
      #1;
      check("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_prot", 32'({axi.awprot, axi.arprot}), 32'd0);
      reset = 1'b0;
      tick();

      // Misaligned read address, two AR stall cycles
      do_read(32'h8000_0006, 32'h1234_5678, OKAY, 2, 0);
      // Zero-wait write
      do_write(32'h8000_0010, 32'hCAFE_F00D, 4'b1100, 0, 0, 0, OKAY);
      // W accepted at once, AW held until the fourth bus cycle
      do_write(32'h8000_0020, 32'h0BAD_CAFE, 4'b0011, 3, 0, 0, OKAY);
      // AW first, W later, stalled B with DECERR
      do_write(32'h4000_0003, 32'h5555_AAAA, 4'b1111, 0, 2, 2, DECERR);
      // Error then clean read, back-to-back
      do_read(32'h0000_0100, 32'hA5A5_0001, SLVERR, 0, 0);
      do_read(32'h0000_0104, 32'h5A5A_0002, OKAY, 0, 3);
      do_read(32'h0000_0108, 32'h0000_0003, EXOKAY, 1, 1);

      // Reset while waiting on R: everything drops, no completion
      req_valid = 1'b1;
      wen       = 1'b0;
      addr      = 32'h1000_0008;
      tick();
      req_valid   = 1'b0;
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      check("abort_rready_before", 32'(axi.rready), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("abort_valids", 32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_rdata", rdata, 32'd0);
      @(posedge clock);
      #3;
      reset = 1'b0;
      tick();
      do_read(32'h1000_0008, 32'h7777_1234, OKAY, 0, 0);

`ifdef LSU_AXIL_MASTER_TIMEOUT_EN
      // Slave never accepts AR: forced error completion after 8 busy cycles
      issue(1'b0, 32'h2000_0000, 32'h0, 4'h0, 32'h0, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         check("to_arvalid_held", 32'(axi.arvalid), 32'd1);
         check("to_no_resp", 32'(resp_valid), 32'd0);
         tick();
      end
      check("to_resp_pulse", 32'(resp_valid), 32'd1);
      check("to_arvalid_drop", 32'(axi.arvalid), 32'd0);
      tick();
      do_read(32'h2000_0004, 32'h0F0F_F0F0, OKAY, 0, 0);
`endif

      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("resp_count", 32'(resp_count), 32'(exp_resps));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
